// File: rtl/time_tmr_pkg.sv
// Shared definitions for the time-redundant TMR protocol.
// Used by the transmitter (time_tmr_replicator) and by the receiving voter.
package time_tmr_pkg;

  // Number of time-redundant copies sent for every element.
  localparam int unsigned NumReplicas = 3;

  // Replica index carried next to every beat.
  typedef enum logic [1:0] {
    REP0 = 2'd0,
    REP1 = 2'd1,
    REP2 = 2'd2
  } replica_t;

  // Transmitter FSM: EMPTY plus one state per replica being offered.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_REP0  = 2'd1,
    ST_REP1  = 2'd2,
    ST_REP2  = 2'd3
  } tmr_state_t;

  // Replica index offered downstream while in a given FSM state.
  function automatic replica_t state_to_replica(input tmr_state_t st);
    case (st)
      ST_REP1: state_to_replica = REP1;
      ST_REP2: state_to_replica = REP2;
      default: state_to_replica = REP0;
    endcase
  endfunction

endpackage

// File: rtl/time_tmr_replicator.sv
// Upstream end of the time-redundant TMR protocol: buffers one element and
// offers it three times back-to-back, all copies tagged with one element ID.
//
// Handshake: a transfer happens on a rising clk_i edge where valid and ready
// are both 1. valid_o, once raised, is held with data_o/id_o/replica_o stable
// until ready_i is seen; valid_o never depends on ready_i while replicating.
module time_tmr_replicator
  import time_tmr_pkg::*;
#(
  parameter type         DataType = logic,
  parameter int unsigned IDSize   = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  DataType           data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output DataType           data_o,
  output logic [IDSize-1:0] id_o,
  output logic [1:0]        replica_o,
  output logic              valid_o,
  input  logic              ready_i
);

  tmr_state_t        state_q, state_d;
  DataType           buf_q, buf_d;
  logic [IDSize-1:0] id_q, id_d;

  // State, element buffer and ID counter; reset drops any element in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
      buf_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      id_q    <= id_d;
    end
  end

  // Next-state and outputs; enable_i only matters in EMPTY so a started
  // triplet always completes.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    id_d      = id_q;
    ready_o   = 1'b0;
    valid_o   = 1'b0;
    data_o    = buf_q;
    id_o      = id_q;
    replica_o = state_to_replica(state_q);

    case (state_q)
      ST_EMPTY: begin
        if (enable_i) begin
          ready_o = 1'b1;
          if (valid_i) begin
            buf_d   = data_i;
            state_d = ST_REP0;
          end
        end else begin
          // Pass-through: single copy, combinational, still ID-tagged.
          valid_o   = valid_i;
          ready_o   = ready_i;
          data_o    = data_i;
          replica_o = REP0;
          if (valid_i && ready_i) begin
            id_d = id_q + IDSize'(1);
          end
        end
      end
      ST_REP0: begin
        valid_o = 1'b1;
        if (ready_i) state_d = ST_REP1;
      end
      ST_REP1: begin
        valid_o = 1'b1;
        if (ready_i) state_d = ST_REP2;
      end
      ST_REP2: begin
        valid_o = 1'b1;
        // Accepting here lets back-to-back elements stream without a bubble.
        ready_o = ready_i;
        if (ready_i) begin
          id_d = id_q + IDSize'(1);
          if (valid_i) begin
            buf_d   = data_i;
            state_d = ST_REP0;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

endmodule

// File: tb/tb_time_tmr_replicator.sv
// Directed bench for time_tmr_replicator (8-bit payload, 4-bit ID).
module tb_time_tmr_replicator;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       enable_i;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_o;
  logic [3:0] id_o;
  logic [1:0] replica_o;
  logic       valid_o;
  logic       ready_i;

  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset
  always #5 clk_i = ~clk_i;

  time_tmr_replicator #(
    .DataType (logic [7:0]),
    .IDSize   (4)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .enable_i  (enable_i),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_o    (data_o),
    .id_o      (id_o),
    .replica_o (replica_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i)
  );

  // driver tasks: inputs change 1 time unit after the edge, checks at +2
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic reset_pulse();
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [7:0] d, input logic [3:0] id,
                          input logic [1:0] rep);
    chk({tag, ".valid"}, 32'(valid_o), 32'd1);
    chk({tag, ".data"}, 32'(data_o), 32'(d));
    chk({tag, ".id"}, 32'(id_o), 32'(id));
    chk({tag, ".rep"}, 32'(replica_o), 32'(rep));
  endtask

  initial begin
    rst_ni   = 1'b0;
    enable_i = 1'b1;
    data_i   = 8'h00;
    valid_i  = 1'b0;
    ready_i  = 1'b1;

    // ---- reset state
    #3;
    chk("rst.valid", 32'(valid_o), 32'd0);
    chk("rst.ready", 32'(ready_o), 32'd1);
    chk("rst.id", 32'(id_o), 32'd0);
    chk("rst.rep", 32'(replica_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    tick();
    settle();
    chk("post_rst.valid", 32'(valid_o), 32'd0);

    // ---- single element A5
    data_i  = 8'hA5;
    valid_i = 1'b1;
    settle();
    chk("single.accept_ready", 32'(ready_o), 32'd1);
    tick();
    valid_i = 1'b0;
    data_i  = 8'hFF;          // must not reach the buffer
    settle();
    chk_beat("single.r0", 8'hA5, 4'd0, 2'd0);
    chk("single.r0_ready", 32'(ready_o), 32'd0);
    tick(); settle();
    chk_beat("single.r1", 8'hA5, 4'd0, 2'd1);
    tick(); settle();
    chk_beat("single.r2", 8'hA5, 4'd0, 2'd2);
    chk("single.r2_ready", 32'(ready_o), 32'd1);
    tick(); settle();
    chk("single.empty_valid", 32'(valid_o), 32'd0);
    chk("single.empty_ready", 32'(ready_o), 32'd1);
    chk("single.id_after", 32'(id_o), 32'd1);

    // ---- back-to-back 01..04 from a fresh counter
    reset_pulse();
    tick();
    data_i  = 8'h01;
    valid_i = 1'b1;
    tick();
    for (int b = 0; b < 12; b++) begin
      if (b % 3 == 2) begin
        data_i  = 8'((b / 3) + 2);
        valid_i = ((b / 3) < 3);
      end
      settle();
      chk_beat($sformatf("b2b.%0d", b), 8'((b / 3) + 1), 4'(b / 3), 2'(b % 3));
      chk($sformatf("b2b.%0d.ready", b), 32'(ready_o), 32'((b % 3) == 2));
      tick();
    end
    valid_i = 1'b0;
    settle();
    chk("b2b.empty_valid", 32'(valid_o), 32'd0);
    chk("b2b.id_after", 32'(id_o), 32'd4);

    // ---- backpressure during REP1
    data_i  = 8'h3C;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    settle();
    chk_beat("bp.r0", 8'h3C, 4'd4, 2'd0);
    tick();
    ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk_beat($sformatf("bp.hold%0d", c), 8'h3C, 4'd4, 2'd1);
      chk($sformatf("bp.hold%0d.ready", c), 32'(ready_o), 32'd0);
      tick();
    end
    ready_i = 1'b1;
    settle();
    chk_beat("bp.release", 8'h3C, 4'd4, 2'd1);
    tick(); settle();
    chk_beat("bp.r2", 8'h3C, 4'd4, 2'd2);
    tick(); settle();
    chk("bp.empty_valid", 32'(valid_o), 32'd0);
    chk("bp.id_after", 32'(id_o), 32'd5);

    // ---- ID wrap: 18 elements from 0, ids 0..15,0,1
    reset_pulse();
    tick();
    for (int e = 0; e < 18; e++) begin
      data_i  = 8'(8'h40 + e);
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      settle();
      chk_beat($sformatf("wrap.e%0d", e), 8'(8'h40 + e), 4'(e % 16), 2'd0);
      tick();
      tick();
      tick();
    end
    settle();
    chk("wrap.id_after", 32'(id_o), 32'd2);

    // ---- enable 1->0 during REP1: triplet completes, then pass-through
    data_i  = 8'h77;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
    enable_i = 1'b0;
    settle();
    chk_beat("en.r1", 8'h77, 4'd2, 2'd1);
    tick(); settle();
    chk_beat("en.r2", 8'h77, 4'd2, 2'd2);
    tick(); settle();
    chk("en.empty_valid", 32'(valid_o), 32'd0);
    chk("en.id_after", 32'(id_o), 32'd3);
    data_i  = 8'h99;
    valid_i = 1'b1;
    settle();
    chk_beat("pt.beat", 8'h99, 4'd3, 2'd0);
    chk("pt.ready", 32'(ready_o), 32'd1);
    tick();
    valid_i = 1'b0;
    settle();
    chk("pt.gone_valid", 32'(valid_o), 32'd0);
    chk("pt.id_after", 32'(id_o), 32'd4);
    ready_i = 1'b0;
    settle();
    chk("pt.ready_follow", 32'(ready_o), 32'd0);
    ready_i  = 1'b1;
    enable_i = 1'b1;
    tick();

    // ---- asynchronous reset during REP1
    data_i  = 8'h55;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
    settle();
    chk_beat("ar.r1", 8'h55, 4'd4, 2'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("ar.valid", 32'(valid_o), 32'd0);
    chk("ar.id", 32'(id_o), 32'd0);
    chk("ar.rep", 32'(replica_o), 32'd0);
    chk("ar.ready", 32'(ready_o), 32'd1);
    #1;
    rst_ni = 1'b1;
    tick();
    tick();
    settle();
    chk("ar.stays_empty", 32'(valid_o), 32'd0);

    // report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
